// File: rtl/jtframe_rom_pkg.sv
// Shared constants and FSM encoding for the object-ROM fetch slot.
// Imported by the interface, the cache array and the top level.
package jtframe_rom_pkg;

    localparam int DW   = 16;
    localparam int NENT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } rom_state_t;

endpackage

// File: rtl/jtframe_obj_romslot_if.sv
// Renderer-side and SDRAM-side signals of the object-ROM fetch slot.
// sdram_req rises and holds until the cycle sdram_ack is sampled high; read data then arrives as a one-cycle data_rdy strobe.
interface jtframe_obj_romslot_if #(
    parameter int AW  = 13,
    parameter int SDW = 22
);
    import jtframe_rom_pkg::*;

    logic           clr;
    logic           cs;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  dout;
    logic           ok;
    logic           sdram_req;
    logic [SDW-1:0] sdram_addr;
    logic           sdram_ack;
    logic           data_rdy;
    logic [DW-1:0]  sdram_din;
    rom_state_t     dbg_state;

    modport slave (
        input  clr, cs, addr, sdram_ack, data_rdy, sdram_din,
        output dout, ok, sdram_req, sdram_addr, dbg_state
    );

    modport master (
        output clr, cs, addr, sdram_ack, data_rdy, sdram_din,
        input  dout, ok, sdram_req, sdram_addr, dbg_state
    );

endinterface

// File: rtl/jtframe_romslot_cache.sv
// Two-entry tag/data/valid array with combinational lookup and a single fill port.
// clr drops the valid bits only; tag and data contents are left stale.
module jtframe_romslot_cache
    import jtframe_rom_pkg::*;
#(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_cs,
    input  logic [AW-1:0] i_addr,
    input  logic          i_fill,
    input  logic          i_fill_idx,
    input  logic [AW-1:0] i_fill_addr,
    input  logic [DW-1:0] i_fill_data,
    output logic          o_hit,
    output logic [DW-1:0] o_hit_data,
    output logic          o_inv_any,
    output logic          o_inv_idx
);

    logic [NENT-1:0] r_valid;
    logic [AW-1:0]   r_tag  [NENT];
    logic [DW-1:0]   r_data [NENT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < NENT; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (i_clr) begin
            r_valid <= '0;
        end else if (i_fill) begin
            r_valid[i_fill_idx] <= 1'b1;
            r_tag[i_fill_idx]   <= i_fill_addr;
            r_data[i_fill_idx]  <= i_fill_data;
        end
    end

    // A tag is only ever filled after it missed, so at most one entry can match.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        for (int i = 0; i < NENT; i++) begin
            if (i_cs && r_valid[i] && r_tag[i] == i_addr) begin
                o_hit      = 1'b1;
                o_hit_data = r_data[i];
            end
        end
    end

    assign o_inv_any = ~&r_valid;
    assign o_inv_idx = r_valid[0];

endmodule

// File: rtl/jtframe_obj_romslot.sv
// Object-ROM fetch slot: 2-entry word cache in front of the SDRAM controller.
// One outstanding read per miss; the returning word may be forwarded straight to dout.
module jtframe_obj_romslot
    import jtframe_rom_pkg::*;
#(
    parameter int             AW     = 13,
    parameter int             SDW    = 22,
    parameter logic [SDW-1:0] OFFSET = '0
) (
    input  logic                   rst,
    input  logic                   clk,
    jtframe_obj_romslot_if.slave   bus
);

    rom_state_t    r_state, w_state_n;
    logic [AW-1:0] r_pend;
    logic          r_abort;
    logic          r_victim;
    logic          r_ok;
    logic [DW-1:0] r_dout;

    logic          w_hit, w_inv_any, w_inv_idx;
    logic [DW-1:0] w_hit_data;
    logic          w_done, w_fill, w_fwd, w_start, w_fill_idx;
    logic          w_ok_n;
    logic [DW-1:0] w_dout_n;

    jtframe_romslot_cache #(.AW(AW)) u_cache (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (bus.clr),
        .i_cs        (bus.cs),
        .i_addr      (bus.addr),
        .i_fill      (w_fill),
        .i_fill_idx  (w_fill_idx),
        .i_fill_addr (r_pend),
        .i_fill_data (bus.sdram_din),
        .o_hit       (w_hit),
        .o_hit_data  (w_hit_data),
        .o_inv_any   (w_inv_any),
        .o_inv_idx   (w_inv_idx)
    );

    // Data arriving together with the ack completes the fetch as if already in WAIT.
    assign w_done = bus.data_rdy &&
                    ((r_state == ST_WAIT) || (r_state == ST_REQ && bus.sdram_ack));
    assign w_fill     = w_done && !r_abort && !bus.clr;
    assign w_fwd      = w_fill && bus.cs && (bus.addr == r_pend);
    assign w_start    = (r_state == ST_IDLE) && bus.cs && !w_hit && !bus.clr;
    assign w_fill_idx = w_inv_any ? w_inv_idx : r_victim;

    always_comb begin
        w_state_n = r_state;
        w_ok_n    = 1'b0;
        w_dout_n  = r_dout;
        case (r_state)
            ST_IDLE: if (w_start) w_state_n = ST_REQ;
            ST_REQ:  if (bus.sdram_ack) w_state_n = bus.data_rdy ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (bus.data_rdy) w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
        if (bus.clr) begin
            w_ok_n = 1'b0;
        end else if (w_fwd) begin
            w_ok_n   = 1'b1;
            w_dout_n = bus.sdram_din;
        end else if (w_hit) begin
            w_ok_n   = 1'b1;
            w_dout_n = w_hit_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pend   <= '0;
            r_abort  <= 1'b0;
            r_victim <= 1'b0;
            r_ok     <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_state <= w_state_n;
            r_ok    <= w_ok_n;
            r_dout  <= w_dout_n;
            if (w_start) r_pend <= bus.addr;
            if (w_done)
                r_abort <= 1'b0;
            else if (bus.clr && r_state != ST_IDLE)
                r_abort <= 1'b1;
            if (bus.clr)
                r_victim <= 1'b0;
            else if (w_fill && !w_inv_any)
                r_victim <= ~r_victim;
        end
    end

    assign bus.sdram_req  = (r_state == ST_REQ);
    assign bus.sdram_addr = OFFSET + {{(SDW-AW){1'b0}}, r_pend};
    assign bus.ok         = r_ok;
    assign bus.dout       = r_dout;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_jtframe_obj_romslot.sv
// Bench for jtframe_obj_romslot: scripted fetches with a dout scoreboard drained on every ok strobe.
module tb_jtframe_obj_romslot;

    localparam logic [21:0] OFFSET = 22'h10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtframe_obj_romslot_if #(.AW(13), .SDW(22)) bus ();

    jtframe_obj_romslot #(.AW(13), .SDW(22), .OFFSET(OFFSET)) dut (
        .rst (rst),
        .clk (clk),
        .bus (bus.slave)
    );

    logic [15:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every ok strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (bus.ok === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_ok", 32'd1, 32'd0);
            else                   chk("sb_dout", bus.dout, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input logic [12:0] a, input logic [15:0] d);
        bus.cs = 1'b1; bus.addr = a;
        exp_q.push_back(d);
        step();
        chk("hit_ok", bus.ok, 1);
        chk("hit_dout", bus.dout, d);
        chk("hit_noreq", bus.sdram_req, 0);
        bus.cs = 1'b0;
    endtask

    // Miss on a, ack after ack_dly cycles, data after rdy_dly more (0: same cycle as ack).
    // wa is the address shown while waiting; abort pulses clr in the first WAIT cycle.
    task automatic fetch(input logic [12:0] a, input logic [12:0] wa, input logic [15:0] din,
                         input int ack_dly, input int rdy_dly, input bit keep, input bit abort);
        bit fwd;
        fwd = !abort && (wa == a);
        bus.cs = 1'b1; bus.addr = a;
        step();
        chk("req_up", bus.sdram_req, 1);
        chk("sd_addr", bus.sdram_addr, OFFSET + a);
        chk("miss_ok", bus.ok, 0);
        for (int i = 1; i < ack_dly; i++) begin
            step();
            chk("req_hold", bus.sdram_req, 1);
        end
        bus.sdram_ack = 1'b1;
        if (rdy_dly == 0) begin
            bus.data_rdy = 1'b1; bus.sdram_din = din;
            if (fwd) exp_q.push_back(din);
        end
        step();
        bus.sdram_ack = 1'b0;
        chk("req_drop", bus.sdram_req, 0);
        if (rdy_dly != 0) begin
            bus.addr = wa;
            if (abort) begin
                bus.clr = 1'b1;
                step();
                bus.clr = 1'b0;
                chk("clr_ok", bus.ok, 0);
            end
            for (int i = 1; i < rdy_dly; i++) step();
            bus.data_rdy = 1'b1; bus.sdram_din = din;
            if (fwd) exp_q.push_back(din);
            step();
        end
        bus.data_rdy = 1'b0;
        chk("fill_ok", bus.ok, {31'd0, fwd});
        if (fwd) chk("fill_dout", bus.dout, din);
        if (!keep) bus.cs = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clr = 0; bus.cs = 0; bus.addr = '0;
        bus.sdram_ack = 0; bus.data_rdy = 0; bus.sdram_din = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_ok", bus.ok, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_req", bus.sdram_req, 0);
        chk("rst_sdaddr", bus.sdram_addr, OFFSET);
        chk("rst_state", bus.dbg_state, 0);

        // Cold miss, then a second word, then hit latency.
        fetch(13'h0040, 13'h0040, 16'hBEEF, 3, 5, 0, 0);
        fetch(13'h0041, 13'h0041, 16'h1234, 1, 1, 0, 0);
        hit(13'h0040, 16'hBEEF);
        step();
        chk("idle_ok", bus.ok, 0);
        chk("idle_dout_hold", bus.dout, 16'hBEEF);

        // Replacement: 0x42 evicts 0x40.
        fetch(13'h0042, 13'h0042, 16'h4242, 2, 2, 0, 0);
        hit(13'h0041, 16'h1234);
        fetch(13'h0040, 13'h0040, 16'hBEE0, 1, 1, 0, 0);

        // Address change mid-fetch: no forward, then 0x200 requested right away.
        fetch(13'h0100, 13'h0200, 16'h1111, 2, 3, 1, 0);
        fetch(13'h0200, 13'h0200, 16'h2222, 1, 2, 0, 0);
        hit(13'h0100, 16'h1111);

        // clr during WAIT discards the fill.
        fetch(13'h0300, 13'h0300, 16'hDEAD, 1, 2, 0, 1);
        fetch(13'h0300, 13'h0300, 16'h3333, 1, 1, 0, 0);
        bus.cs = 1'b1; bus.addr = 13'h0300; bus.clr = 1'b1;
        step();
        bus.clr = 1'b0; bus.cs = 1'b0;
        chk("clr_hit_ok", bus.ok, 0);
        chk("clr_hit_req", bus.sdram_req, 0);
        // Invalidated word misses again; ack and data in the same cycle.
        fetch(13'h0300, 13'h0300, 16'h3334, 1, 0, 0, 0);

        // Reset in REQ.
        bus.cs = 1'b1; bus.addr = 13'h0500;
        step();
        chk("pre_rst_req", bus.sdram_req, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; bus.cs = 1'b0;
        chk("mid_rst_req", bus.sdram_req, 0);
        chk("mid_rst_ok", bus.ok, 0);
        chk("mid_rst_state", bus.dbg_state, 0);
        bus.data_rdy = 1'b1; bus.sdram_din = 16'hF00D;
        step();
        bus.data_rdy = 1'b0;
        chk("stray_rdy_ok", bus.ok, 0);
        chk("stray_rdy_req", bus.sdram_req, 0);
        fetch(13'h0500, 13'h0500, 16'h5555, 2, 2, 0, 0);
        hit(13'h0500, 16'h5555);

        repeat (2) step();
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
